// File: rtl/clk_phase_shift.sv
// Multi-channel phase shifter: measures the period and high time of i_clk0 in std_clk
// cycles and regenerates NUM_CH copies, each delayed by a programmable fraction of a period.
module clk_phase_shift #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned PHASE_W    = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                      std_clk,
  input  logic                      reset_n,
  input  logic                      i_clk0,
  input  logic [NUM_CH*PHASE_W-1:0] i_phase,
  output logic [NUM_CH-1:0]         o_clk,
  output logic                      o_locked,
  output logic [CNT_W-1:0]          o_period
);

  localparam int unsigned        LOCK_W    = $clog2(LOCK_COUNT + 1);
  localparam int unsigned        PROD_W    = CNT_W + PHASE_W;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [LOCK_W-1:0]  LOCK_FULL = LOCK_W'(LOCK_COUNT);

  typedef enum logic {
    MEAS_IDLE,
    MEAS_ARMED
  } meas_t;

  meas_t             meas;
  logic [2:0]        sync;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_q;
  logic [CNT_W-1:0]  high_q;
  logic [CNT_W-1:0]  delay_q [NUM_CH];
  logic [LOCK_W-1:0] lock_cnt;

  logic              rise;
  logic              fall;
  logic              timeout;
  logic              measure;
  logic              in_tol;
  logic [CNT_W-1:0]  period_new;
  logic [CNT_W-1:0]  period_diff;
  logic [LOCK_W-1:0] lock_inc;
  logic [PROD_W-1:0] prod      [NUM_CH];
  logic [CNT_W-1:0]  delay_new [NUM_CH];
  logic [CNT_W:0]    pos       [NUM_CH];
  logic [NUM_CH-1:0] clk_next;

  // A rise coinciding with a timeout re-arms measurement but is not itself measured.
  always_comb begin
    rise        = sync[1] & ~sync[2];
    fall        = ~sync[1] & sync[2];
    timeout     = (cnt == CNT_MAX);
    measure     = rise & (meas == MEAS_ARMED) & ~timeout;
    period_new  = cnt + CNT_W'(1);
    period_diff = (period_new >= period_q) ? period_new - period_q : period_q - period_new;
    in_tol      = (period_diff <= CNT_W'(1));
    lock_inc    = (lock_cnt == LOCK_FULL) ? lock_cnt : lock_cnt + LOCK_W'(1);
  end

  always_comb begin
    prod      = '{default: '0};
    delay_new = '{default: '0};
    pos       = '{default: '0};
    clk_next  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      prod[k]      = PROD_W'(period_new) * PROD_W'(i_phase[k*PHASE_W +: PHASE_W]);
      delay_new[k] = prod[k][PROD_W-1:PHASE_W];
      // Position within the shifted period; wraps once when cnt has not yet reached the delay.
      if (cnt >= delay_q[k])
        pos[k] = {1'b0, cnt} - {1'b0, delay_q[k]};
      else
        pos[k] = {1'b0, cnt} + {1'b0, period_q} - {1'b0, delay_q[k]};
      clk_next[k] = o_locked & (pos[k] < {1'b0, high_q});
    end
  end

  always_ff @(posedge std_clk) begin
    if (!reset_n) begin
      meas     <= MEAS_IDLE;
      sync     <= '0;
      cnt      <= '0;
      period_q <= '0;
      high_q   <= '0;
      lock_cnt <= '0;
      o_clk    <= '0;
      o_locked <= 1'b0;
      o_period <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) delay_q[k] <= '0;
    end else begin
      sync  <= {sync[1:0], i_clk0};
      o_clk <= clk_next;

      if (rise)
        cnt <= '0;
      else if (!timeout)
        cnt <= cnt + CNT_W'(1);

      if (fall)
        high_q <= period_new;

      if (measure) begin
        period_q <= period_new;
        o_period <= period_new;
        for (int unsigned k = 0; k < NUM_CH; k++) delay_q[k] <= delay_new[k];
        if (in_tol) begin
          lock_cnt <= lock_inc;
          o_locked <= (lock_inc == LOCK_FULL);
        end else begin
          lock_cnt <= '0;
          o_locked <= 1'b0;
        end
      end else if (timeout) begin
        lock_cnt <= '0;
        o_locked <= 1'b0;
      end

      if (rise)
        meas <= MEAS_ARMED;
      else if (timeout)
        meas <= MEAS_IDLE;
    end
  end

endmodule

// File: tb/tb_clk_phase_shift.sv
// Scoreboard bench for clk_phase_shift: a per-edge reference model predicts every output,
// and a negedge monitor pops and compares; directed checks cover lock timing and delays.
module tb_clk_phase_shift;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned CNT_W      = 10;
  localparam int unsigned PHASE_W    = 8;
  localparam int unsigned LOCK_COUNT = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic                      std_clk = 1'b0;
  logic                      reset_n;
  logic                      i_clk0;
  logic [NUM_CH*PHASE_W-1:0] i_phase;
  logic [NUM_CH-1:0]         o_clk;
  logic                      o_locked;
  logic [CNT_W-1:0]          o_period;

  clk_phase_shift #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .PHASE_W(PHASE_W),
    .LOCK_COUNT(LOCK_COUNT)
  ) dut (
    .std_clk (std_clk),
    .reset_n (reset_n),
    .i_clk0  (i_clk0),
    .i_phase (i_phase),
    .o_clk   (o_clk),
    .o_locked(o_locked),
    .o_period(o_period)
  );

  always #5 std_clk = ~std_clk;

  typedef struct {
    logic [NUM_CH-1:0] clk;
    logic              locked;
    int                period;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: age = cycles since the last detected rise, seen[] = synchronized input history.
  int age, per, hi, streak;
  int dly [NUM_CH];
  bit armed, locked;
  bit seen [3];

  function automatic int phase_of(input int k);
    logic [PHASE_W-1:0] p;
    p = i_phase[k*PHASE_W +: PHASE_W];
    return int'(p);
  endfunction

  task automatic model_edge();
    exp_t e;
    bit   rise_ev, fall_ev, tmo, tol;
    int   pos, newp, d;
    if (!reset_n) begin
      age = 0; per = 0; hi = 0; streak = 0; armed = 0; locked = 0;
      foreach (dly[k]) dly[k] = 0;
      seen = '{0, 0, 0};
      e.clk = '0; e.locked = 0; e.period = 0;
    end else begin
      rise_ev = seen[1] && !seen[2];
      fall_ev = !seen[1] && seen[2];
      e.clk = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pos = (age >= dly[k]) ? age - dly[k] : age + per - dly[k];
        e.clk[k] = locked && (pos < hi);
      end
      tmo = (age == CNT_MAX);
      if (fall_ev) hi = (age + 1) % (CNT_MAX + 1);
      if (rise_ev) begin
        if (armed && !tmo) begin
          newp = age + 1;
          d = newp - per;
          if (d < 0) d = -d;
          tol = (d <= 1);
          if (!tol) streak = 0;
          else if (streak < LOCK_COUNT) streak++;
          locked = (streak == LOCK_COUNT);
          per = newp;
          for (int k = 0; k < NUM_CH; k++) dly[k] = (newp * phase_of(k)) >> PHASE_W;
        end else if (tmo) begin
          streak = 0; locked = 0;
        end
        armed = 1;
        age = 0;
      end else if (tmo) begin
        streak = 0; locked = 0; armed = 0;
      end else begin
        age++;
      end
      e.locked = locked;
      e.period = per;
      seen[2] = seen[1];
      seen[1] = seen[0];
      seen[0] = i_clk0;
    end
    sb.push_back(e);
  endtask

  // Monitor: pops one prediction per edge and tracks the latest output edges per channel.
  int cyc = 0;
  int rise_t [NUM_CH];
  int fall_t [NUM_CH];
  logic [NUM_CH-1:0] prev_clk = '0;

  initial begin
    exp_t e;
    foreach (rise_t[k]) begin rise_t[k] = 0; fall_t[k] = 0; end
    forever begin
      @(negedge std_clk);
      cyc++;
      for (int k = 0; k < NUM_CH; k++) begin
        if (o_clk[k] && !prev_clk[k]) rise_t[k] = cyc;
        if (!o_clk[k] && prev_clk[k]) fall_t[k] = cyc;
      end
      prev_clk = o_clk;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("o_clk", 32'(o_clk), 32'(e.clk));
        check("o_locked", 32'(o_locked), 32'(e.locked));
        check("o_period", 32'(o_period), 32'(e.period));
      end
    end
  end

  task automatic tick();
    @(posedge std_clk);
    model_edge();
    @(negedge std_clk);
  endtask

  task automatic cycles(input bit lvl, input int n);
    repeat (n) begin
      i_clk0 = lvl;
      tick();
    end
  endtask

  task automatic clk_period(input int p, input int h);
    cycles(1, h);
    cycles(0, p - h);
  endtask

  task automatic set_phase(input int k, input int v);
    i_phase[k*PHASE_W +: PHASE_W] = PHASE_W'(v);
  endtask

  // One period with an occasional phase rewrite at a random point inside it.
  task automatic rand_period(input int p, input int h);
    int at;
    at = (($urandom_range(0, 3) == 0)) ? int'($urandom_range(0, p - 1)) : -1;
    for (int c = 0; c < p; c++) begin
      if (c == at) set_phase(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 255)));
      i_clk0 = (c < h);
      tick();
    end
  endtask

  initial begin
    int p, h, reps;
    reset_n = 1'b0;
    i_clk0  = 1'b0;
    i_phase = '0;
    tick();
    tick();
    check("reset_locked", 32'(o_locked), 0);
    check("reset_clk", 32'(o_clk), 0);
    check("reset_period", 32'(o_period), 0);
    reset_n = 1'b1;

    // 50% duty, ch0 at 90 deg, ch1 at 0 deg
    set_phase(0, 64);
    set_phase(1, 0);
    repeat (5) clk_period(120, 60);
    check("unlocked_before_rise6", 32'(o_locked), 0);
    clk_period(120, 60);
    check("locked_at_rise6", 32'(o_locked), 1);
    repeat (3) clk_period(120, 60);
    check("period_120", 32'(o_period), 120);
    check("delay_90deg", 32'(rise_t[0] - rise_t[1]), 30);
    check("width_50pct", 32'(fall_t[0] - rise_t[0]), 60);

    // 180 and 270 deg on ch1 relative to ch0
    set_phase(0, 0);
    set_phase(1, 128);
    repeat (3) clk_period(120, 60);
    check("delay_180deg", 32'(rise_t[1] - rise_t[0]), 60);
    check("inverse_180deg", 32'(o_clk[1]), 32'(!o_clk[0]));
    set_phase(1, 192);
    repeat (3) clk_period(120, 60);
    check("delay_270deg", 32'(rise_t[1] - rise_t[0]), 90);

    // 25% duty
    set_phase(0, 64);
    set_phase(1, 0);
    repeat (3) clk_period(120, 30);
    check("width_25pct", 32'(fall_t[0] - rise_t[0]), 30);
    check("delay_25pct", 32'(rise_t[0] - rise_t[1]), 30);

    // reference stalls high past timeout, then restarts
    cycles(1, 1100);
    check("timeout_unlock", 32'(o_locked), 0);
    check("timeout_clk", 32'(o_clk), 0);
    cycles(0, 60);
    repeat (4) clk_period(120, 60);
    check("relock_not_yet", 32'(o_locked), 0);
    clk_period(120, 60);
    check("relock_rise5", 32'(o_locked), 1);

    // phase change in the middle of a period
    set_phase(0, 0);
    repeat (3) clk_period(120, 60);
    cycles(1, 60);
    cycles(0, 20);
    set_phase(0, 64);
    cycles(0, 40);
    repeat (2) clk_period(120, 60);
    check("midperiod_phase", 32'(rise_t[0] - rise_t[1]), 30);

    // reset pulse during the high phase, relock, then a period jump
    cycles(1, 30);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midreset_locked", 32'(o_locked), 0);
    check("midreset_clk", 32'(o_clk), 0);
    check("midreset_period", 32'(o_period), 0);
    cycles(1, 30);
    cycles(0, 60);
    repeat (8) clk_period(120, 60);
    check("relock_after_reset", 32'(o_locked), 1);
    clk_period(80, 40);
    cycles(1, 5);
    check("jump_unlock", 32'(o_locked), 0);
    check("jump_period", 32'(o_period), 80);
    cycles(1, 35);
    cycles(0, 40);

    // longest measurable gap, then rise coincident with timeout
    clk_period(1023, 500);
    clk_period(1023, 500);
    clk_period(1024, 500);
    clk_period(1025, 500);
    repeat (3) clk_period(200, 100);

    // randomized periods, duties, jitter and phases (including 0 and 255)
    set_phase(0, 255);
    set_phase(1, 0);
    repeat (30) begin
      p = int'($urandom_range(40, 400));
      h = int'($urandom_range(1, p - 2));
      reps = int'($urandom_range(1, 7));
      for (int k = 0; k < NUM_CH; k++) set_phase(k, int'($urandom_range(0, 255)));
      repeat (reps) rand_period(p + int'($urandom_range(0, 2)) - 1, h);
    end

    cycles(0, 4);
    @(negedge std_clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
